// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN_DEF     : default PC / address width
//   RESET_PC_DEF : default fetch PC after reset
//   INSTR_W      : instruction word width
//   is_aligned   : true when a PC's two low bits are zero
package ifetch_unit_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned INSTR_W      = 32;

    function automatic logic is_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_unit_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and asynchronous active-high reset.
//   clk, rst   : clock, async active-high reset
//   flush      : drop all entries; wins over push/pop in the same cycle
//   push/data  : write push_data when not full
//   pop        : release the head entry when not empty
//   head_data  : current head entry (from storage registers)
//   count      : number of valid entries; full/empty flags
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a synchronous
// instruction BRAM of fixed latency, buffers returned words with their PC and presents
// them to decode over valid/ready. Redirects flush everything in flight and buffered.
//   clk, rst                : clock, async active-high reset
//   redirect_valid/pc       : taken branch/jump and its target
//   imem_en/addr/rdata      : BRAM read port (word address, MEM_LATENCY read latency)
//   inst_valid/ready        : decode handshake; inst_data/inst_pc describe the head
//   fetch_fault             : sticky, set by a misaligned redirect target; halts issue
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
    parameter int unsigned     IMEM_ADDR_W = 10,
    parameter int unsigned     MEM_LATENCY = 1,
    parameter int unsigned     FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0]     imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INSTR_W-1:0]     inst_data,
    output logic [XLEN-1:0]        inst_pc,
    output logic                   fetch_fault
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("ifetch_unit: RESET_PC must be 4-byte aligned");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_bad_latency
        $error("ifetch_unit: MEM_LATENCY must be 1..3");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < MEM_LATENCY + 2) begin : g_bad_depth
        $error("ifetch_unit: FIFO_DEPTH must be a power of 2 and >= MEM_LATENCY+2");
    end

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = INSTR_W + XLEN;

    logic [XLEN-1:0]        fpc_q, fpc_d;
    logic                   fault_q, fault_d;
    logic [MEM_LATENCY-1:0] tag_vld_q;
    logic [XLEN-1:0]        tag_pc_q [MEM_LATENCY];
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full, fifo_empty;
    logic [EW-1:0]          head_data;
    logic                   credit_ok, issue, push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    // Buffered plus in-flight words may never exceed the FIFO, so every return has a slot.
    assign credit_ok = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
    assign issue     = !rst && !redirect_valid && !fault_q && credit_ok;
    assign imem_en   = issue;
    assign imem_addr = fpc_q[IMEM_ADDR_W+1:2];

    assign push       = tag_vld_q[MEM_LATENCY-1];
    assign inst_valid = !fifo_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = fifo_empty ? '0 : head_data[EW-1:XLEN];
    assign inst_pc    = fifo_empty ? '0 : head_data[XLEN-1:0];
    assign fetch_fault = fault_q;

    always_comb begin
        fpc_d   = fpc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            if (is_aligned(redirect_pc[1:0])) begin
                fpc_d   = redirect_pc;
                fault_d = 1'b0;
            end else begin
                fault_d = 1'b1;
            end
        end else if (issue) begin
            fpc_d = fpc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            fpc_q   <= fpc_d;
            fault_q <= fault_d;
        end
    end

    // Tag pipe tracks each outstanding read so the returning word is paired with its PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_pc_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= issue;
            tag_pc_q[0]  <= fpc_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1] && !redirect_valid;
                tag_pc_q[i]  <= tag_pc_q[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({imem_rdata, tag_pc_q[MEM_LATENCY-1]}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !redirect_valid))
        else $error("ifetch_unit: instruction buffer overflow");

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: MEM_LATENCY=1, FIFO_DEPTH=4
    logic        rst, redirect_valid, inst_ready, imem_en, inst_valid, fetch_fault;
    logic [31:0] redirect_pc, imem_rdata, inst_data, inst_pc;
    logic [9:0]  imem_addr;

    // DUT B: MEM_LATENCY=3, FIFO_DEPTH=8
    logic        rst3, rv3, ready3, en3, valid3, fault3;
    logic [31:0] rpc3, rdata3, data3, pc3;
    logic [9:0]  addr3;

    int passed = 0;
    int total  = 0;

    function automatic logic [31:0] img(input logic [9:0] a);
        return 32'h5EED_0000 ^ {12'h000, a, 10'h000} ^ {22'h0, a};
    endfunction

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    ifetch_unit #(
        .MEM_LATENCY (3),
        .FIFO_DEPTH  (8)
    ) dut3 (
        .clk            (clk),
        .rst            (rst3),
        .redirect_valid (rv3),
        .redirect_pc    (rpc3),
        .imem_en        (en3),
        .imem_addr      (addr3),
        .imem_rdata     (rdata3),
        .inst_valid     (valid3),
        .inst_ready     (ready3),
        .inst_data      (data3),
        .inst_pc        (pc3),
        .fetch_fault    (fault3)
    );

    // BRAM models
    always @(posedge clk) imem_rdata <= img(imem_addr);

    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= img(addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata3 = p3[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic        vld;
        logic [31:0] pc;
        logic        flt;
        logic        chk_addr;
        logic [9:0]  addr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic en, input logic vld,
                                input logic [31:0] pc, input logic flt, input logic ca,
                                input logic [9:0] addr);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.en = en; v.vld = vld;
        v.pc = pc; v.flt = flt; v.chk_addr = ca; v.addr = addr;
        vecs.push_back(v);
    endfunction

    initial begin
        int          hs;
        logic [31:0] exp_next;

        // Reset, then stream from PC 0 (first valid in cycle 3)
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h000);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h001);
        for (int k = 0; k < 6; k++) add(0, 1, 0, 0, 1, 1, 32'(4 * k), 0, 0, 0);
        // Decode stalls for 10 cycles: two more issues, then credits run out
        add(0, 0, 0, 0, 1, 1, 32'd24, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'd24, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, 1, 32'd24, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 32'd24, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 1, 1, 32'(28 + 4 * k), 0, 0, 0);
        // Reset mid-stream, build 3 buffered entries, then redirect to 0x100
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 10'h000);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h040);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 1, 32'(32'h100 + 4 * k), 0, 0, 0);
        // Misaligned redirect faults; aligned redirect recovers
        add(0, 1, 1, 32'h102, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 32'h200, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h080);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h200, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h204, 0, 0, 0);
        // PC wrap at the top of the address space
        add(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h3FE);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h3FF);
        add(0, 1, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 1, 10'h000);
        add(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 1, 10'h001);
        add(0, 1, 0, 0, 1, 1, 32'h0000_0000, 0, 0, 0);
        // Back-to-back redirects: last one wins
        add(0, 1, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 32'h400, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 10'h100);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h400, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h404, 0, 0, 0);

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        rst3 = 1'b1; rv3 = 1'b0; rpc3 = '0; ready3 = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            inst_ready     = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("v%0d imem_en", i), 32'(imem_en), 32'(vecs[i].en));
            check($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].vld));
            check($sformatf("v%0d fetch_fault", i), 32'(fetch_fault), 32'(vecs[i].flt));
            if (vecs[i].vld) begin
                check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].pc);
                check($sformatf("v%0d inst_data", i), inst_data, img(vecs[i].pc[11:2]));
            end
            if (vecs[i].rst) begin
                check($sformatf("v%0d rst inst_pc", i), inst_pc, 32'h0);
                check($sformatf("v%0d rst inst_data", i), inst_data, 32'h0);
            end
            if (vecs[i].chk_addr) begin
                check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            end
            @(posedge clk); #1;
        end

        // Latency-3 instance: random ready, periodic redirects, reset pulse mid-stream
        rst3 = 1'b0;
        exp_next = 32'h0;
        hs = 0;
        for (int c = 0; c < 600; c++) begin
            rst3   = (c == 300);
            ready3 = ($urandom_range(0, 3) != 0);
            rv3    = !rst3 && (c % 47 == 20);
            rpc3   = 32'($urandom_range(0, 1023)) << 2;
            @(negedge clk);
            if (rst3) begin
                check("t6 rst imem_en", 32'(en3), 32'h0);
                check("t6 rst inst_valid", 32'(valid3), 32'h0);
                check("t6 rst inst_pc", pc3, 32'h0);
                check("t6 rst inst_data", data3, 32'h0);
                check("t6 rst fetch_fault", 32'(fault3), 32'h0);
                exp_next = 32'h0;
            end else if (rv3) begin
                check("t6 redirect inst_valid", 32'(valid3), 32'h0);
                exp_next = rpc3;
            end else if (valid3 && ready3) begin
                check($sformatf("t6 c%0d inst_pc", c), pc3, exp_next);
                check($sformatf("t6 c%0d inst_data", c), data3, img(exp_next[11:2]));
                exp_next = exp_next + 32'd4;
                hs++;
            end
            @(posedge clk); #1;
        end
        check("t6 progress (handshakes > 200)", 32'(hs > 200), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
